delay_pipe: RTL and testbench

- Parametrised successor to the fixed delay line used across the pipeline.
- Delays a WIDTH-bit word plus a valid bit by a runtime-selectable number of cycles, 0..MAX_DELAY.
- Adds stall (hold), flush (bubble-clear) and an occupancy count.
- Used in hazard/forwarding paths where stage alignment varies with instruction class.

---
 rtl/delay_pipe_if.sv | 40 ++++
 rtl/delay_pipe.sv | 59 +++++
 tb/tb_delay_pipe.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/delay_pipe_if.sv
// Bundles for delay_pipe: the clock/reset control pair and the data-path bus.
//
// Handshake semantics: there is no ready. in_valid only marks the word on
// `in` as meaningful. A valid word is captured on any rising edge where
// flush=0 and stall=0. stall is the only hold mechanism, and it freezes
// every stage. out_valid marks `out` as a delayed valid word. Consumers must
// take `out` in the cycle it is presented.

interface util_control_if;
  logic clock;
  logic reset;  // asynchronous, active-low

  modport master (output clock, output reset);
  modport slave  (input clock, input reset);
endinterface

interface delay_pipe_if #(
  parameter int WIDTH     = 4,
  parameter int MAX_DELAY = 4
);
  localparam int SW = $clog2(MAX_DELAY + 1);

  logic             stall;
  logic             flush;
  logic [SW-1:0]    sel;
  logic             in_valid;
  logic [WIDTH-1:0] in;
  logic             out_valid;
  logic [WIDTH-1:0] out;
  logic [SW-1:0]    occupancy;

  modport master (
    output stall, output flush, output sel, output in_valid, output in,
    input  out_valid, input out, input occupancy
  );
  modport slave (
    input  stall, input flush, input sel, input in_valid, input in,
    output out_valid, output out, output occupancy
  );
endinterface

// File: rtl/delay_pipe.sv
// Runtime-selectable delay line (0..MAX_DELAY cycles) for a word and its
// valid bit, with stall, flush and an occupancy count over all stages.
// Invalid slots always carry RESET_VALUE, so stale data never leaks to out.

module delay_pipe #(
  parameter int               WIDTH       = 4,
  parameter int               MAX_DELAY   = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  util_control_if.slave ctrl,
  delay_pipe_if.slave   bus
);

  localparam int SW = $clog2(MAX_DELAY + 1);

  logic [WIDTH-1:0]     d [MAX_DELAY];
  logic [MAX_DELAY-1:0] v;
  logic [SW-1:0]        k;
  logic [SW-1:0]        cnt;

  // Stage registers: flush beats stall, stall beats shift; bubbles load RESET_VALUE.
  always_ff @(posedge ctrl.clock or negedge ctrl.reset) begin
    if (!ctrl.reset) begin
      for (int i = 0; i < MAX_DELAY; i++) d[i] <= RESET_VALUE;
      v <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < MAX_DELAY; i++) d[i] <= RESET_VALUE;
      v <= '0;
    end else if (!bus.stall) begin
      d[0] <= bus.in_valid ? bus.in : RESET_VALUE;
      v[0] <= bus.in_valid;
      for (int i = 1; i < MAX_DELAY; i++) begin
        d[i] <= d[i-1];
        v[i] <= v[i-1];
      end
    end
  end

  // Output mux: clamp sel to MAX_DELAY; a delay of 0 is a pure combinational bypass.
  always_comb begin
    k = (bus.sel > SW'(MAX_DELAY)) ? SW'(MAX_DELAY) : bus.sel;
    bus.out       = bus.in;
    bus.out_valid = bus.in_valid;
    for (int i = 0; i < MAX_DELAY; i++) begin
      if (int'(k) == i + 1) begin
        bus.out       = d[i];
        bus.out_valid = v[i];
      end
    end
  end

  // Occupancy: popcount of every stage's valid bit, independent of sel.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < MAX_DELAY; i++) cnt = cnt + SW'(v[i]);
    bus.occupancy = cnt;
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Directed bench for delay_pipe (WIDTH=4, MAX_DELAY=4, RESET_VALUE=0).
// Each vector applies inputs, checks the combinational outputs against the
// state left by earlier edges, then advances one rising edge.

module tb_delay_pipe;

  typedef struct {
    logic       stall;
    logic       flush;
    logic [2:0] sel;
    logic       in_valid;
    logic [3:0] in_w;
    logic       exp_valid;
    logic [3:0] exp_out;
    logic [2:0] exp_occ;
  } vec_t;

  util_control_if ctrl_if ();
  delay_pipe_if #(.WIDTH(4), .MAX_DELAY(4)) bus ();

  delay_pipe #(.WIDTH(4), .MAX_DELAY(4), .RESET_VALUE(4'h0)) dut (
    .ctrl (ctrl_if),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  // Clock and reset
  initial ctrl_if.clock = 1'b0;
  always #5 ctrl_if.clock = ~ctrl_if.clock;

  function automatic vec_t mk(input logic st, input logic fl, input logic [2:0] sl,
                              input logic iv, input logic [3:0] di,
                              input logic ev, input logic [3:0] eo, input logic [2:0] ec);
    vec_t r;
    r.stall = st; r.flush = fl; r.sel = sl; r.in_valid = iv; r.in_w = di;
    r.exp_valid = ev; r.exp_out = eo; r.exp_occ = ec;
    return r;
  endfunction

  task automatic tick();
    @(posedge ctrl_if.clock);
    #1;
  endtask

  task automatic chk_outputs(input string name, input int idx,
                             input logic ev, input logic [3:0] eo, input logic [2:0] ec);
    checks++;
    if (bus.out_valid !== ev) begin
      failures++;
      $display("FAIL %s[%0d] out_valid got=%0b exp=%0b", name, idx, bus.out_valid, ev);
    end
    checks++;
    if (bus.out !== eo) begin
      failures++;
      $display("FAIL %s[%0d] out got=%0h exp=%0h", name, idx, bus.out, eo);
    end
    checks++;
    if (bus.occupancy !== ec) begin
      failures++;
      $display("FAIL %s[%0d] occupancy got=%0d exp=%0d", name, idx, bus.occupancy, ec);
    end
  endtask

  // Driver: apply one vector, check, then take one edge
  task automatic run_vec(input vec_t t, input string name, input int idx);
    bus.stall    = t.stall;
    bus.flush    = t.flush;
    bus.sel      = t.sel;
    bus.in_valid = t.in_valid;
    bus.in       = t.in_w;
    #1;
    chk_outputs(name, idx, t.exp_valid, t.exp_out, t.exp_occ);
    tick();
  endtask

  initial begin
    // Reset then stream with sel=2 (occupancy counts all four stages)
    for (int r = 0; r < 7; r++)
      vecs.push_back(mk(0, 0, 3'd2, 1, 4'(r), (r >= 2), (r >= 2) ? 4'(r - 2) : 4'h0,
                        (r < 4) ? 3'(r) : 3'd4));
    vecs.push_back(mk(0, 1, 3'd2, 1, 4'h7, 1, 4'h5, 3'd4));  // flush clears
    // Bubbles with sel=1: 3 / bubble(F) / 5
    vecs.push_back(mk(0, 0, 3'd1, 1, 4'h3, 0, 4'h0, 3'd0));
    vecs.push_back(mk(0, 0, 3'd1, 0, 4'hF, 1, 4'h3, 3'd1));
    vecs.push_back(mk(0, 0, 3'd1, 1, 4'h5, 0, 4'h0, 3'd1));
    vecs.push_back(mk(0, 0, 3'd1, 0, 4'h0, 1, 4'h5, 3'd2));
    // Bypass, including under stall
    vecs.push_back(mk(0, 0, 3'd0, 1, 4'hA, 1, 4'hA, 3'd2));
    vecs.push_back(mk(1, 0, 3'd0, 1, 4'hA, 1, 4'hA, 3'd2));
    vecs.push_back(mk(1, 0, 3'd0, 0, 4'hC, 0, 4'hC, 3'd2));
    // Clamp: sel above MAX_DELAY reads stage 3
    vecs.push_back(mk(0, 0, 3'd7, 1, 4'h6, 0, 4'h0, 3'd2));
    vecs.push_back(mk(1, 0, 3'd7, 1, 4'h2, 1, 4'h5, 3'd3));
    vecs.push_back(mk(1, 0, 3'd4, 1, 4'h2, 1, 4'h5, 3'd3));
    vecs.push_back(mk(1, 0, 3'd5, 1, 4'h2, 1, 4'h5, 3'd3));
    // Bypass ignores flush; flush empties the stages
    vecs.push_back(mk(0, 1, 3'd0, 1, 4'h9, 1, 4'h9, 3'd3));
    vecs.push_back(mk(0, 0, 3'd4, 0, 4'h0, 0, 4'h0, 3'd0));

    bus.stall = 0; bus.flush = 0; bus.sel = 3'd2; bus.in_valid = 1; bus.in = 4'h5;
    ctrl_if.reset = 1'b0;
    #1;
    chk_outputs("reset", 0, 0, 4'h0, 3'd0);
    @(posedge ctrl_if.clock);
    @(posedge ctrl_if.clock);
    #1;
    chk_outputs("reset", 1, 0, 4'h0, 3'd0);
    ctrl_if.reset = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i], "tbl", i);

    // Stall with sel=3: out holds 6, the stalled word E is never captured
    run_vec(mk(0, 0, 3'd3, 1, 4'h5, 0, 4'h0, 3'd0), "stall", 0);
    run_vec(mk(0, 0, 3'd3, 1, 4'h6, 0, 4'h0, 3'd1), "stall", 1);
    run_vec(mk(0, 0, 3'd3, 1, 4'h7, 0, 4'h0, 3'd2), "stall", 2);
    run_vec(mk(0, 0, 3'd3, 1, 4'h8, 1, 4'h5, 3'd3), "stall", 3);
    run_vec(mk(1, 0, 3'd3, 1, 4'hE, 1, 4'h6, 3'd4), "stall", 4);
    run_vec(mk(1, 0, 3'd3, 1, 4'hE, 1, 4'h6, 3'd4), "stall", 5);
    run_vec(mk(0, 0, 3'd3, 0, 4'h0, 1, 4'h6, 3'd4), "stall", 6);
    run_vec(mk(0, 0, 3'd3, 0, 4'h0, 1, 4'h7, 3'd3), "stall", 7);
    run_vec(mk(0, 0, 3'd3, 0, 4'h0, 1, 4'h8, 3'd2), "stall", 8);
    run_vec(mk(0, 0, 3'd3, 0, 4'h0, 0, 4'h0, 3'd1), "stall", 9);

    // Flush beats stall with sel=4; 9 is dropped, A..F resumes after 4 cycles
    run_vec(mk(0, 0, 3'd4, 1, 4'h1, 0, 4'h0, 3'd0), "flush", 0);
    run_vec(mk(0, 0, 3'd4, 1, 4'h2, 0, 4'h0, 3'd1), "flush", 1);
    run_vec(mk(0, 0, 3'd4, 1, 4'h3, 0, 4'h0, 3'd2), "flush", 2);
    run_vec(mk(0, 0, 3'd4, 1, 4'h4, 0, 4'h0, 3'd3), "flush", 3);
    run_vec(mk(1, 1, 3'd4, 1, 4'h9, 1, 4'h1, 3'd4), "flush", 4);
    run_vec(mk(0, 0, 3'd4, 1, 4'hA, 0, 4'h0, 3'd0), "flush", 5);
    run_vec(mk(0, 0, 3'd4, 1, 4'hB, 0, 4'h0, 3'd1), "flush", 6);
    run_vec(mk(0, 0, 3'd4, 1, 4'hC, 0, 4'h0, 3'd2), "flush", 7);
    run_vec(mk(0, 0, 3'd4, 1, 4'hD, 0, 4'h0, 3'd3), "flush", 8);
    run_vec(mk(0, 0, 3'd4, 1, 4'hE, 1, 4'hA, 3'd4), "flush", 9);
    run_vec(mk(0, 0, 3'd4, 1, 4'hF, 1, 4'hB, 3'd4), "flush", 10);

    // Async reset between edges with all four stages valid (C at stage 3)
    bus.stall = 0; bus.flush = 0; bus.sel = 3'd4; bus.in_valid = 1; bus.in = 4'h7;
    #1;
    chk_outputs("areset", 0, 1, 4'hC, 3'd4);
    #1;
    ctrl_if.reset = 1'b0;
    #1;
    chk_outputs("areset", 1, 0, 4'h0, 3'd0);
    bus.sel = 3'd0; bus.in = 4'h3;
    #1;
    chk_outputs("areset", 2, 1, 4'h3, 3'd0);
    bus.sel = 3'd1; bus.in = 4'h7;
    tick();
    chk_outputs("areset", 3, 0, 4'h0, 3'd0);
    ctrl_if.reset = 1'b1;
    #1;
    chk_outputs("areset", 4, 0, 4'h0, 3'd0);
    tick();
    chk_outputs("areset", 5, 1, 4'h7, 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
